// File: rtl/mydowncounter_if.sv
// Control/status bundle for the loadable down-counting timer.
// The master drives the controls; the slave is the counter.
interface mydowncounter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             start;
  logic             pause;
  logic             stop;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output load, din, start, pause, stop,
    input  out, busy, done
  );

  modport slave (
    input  load, din, start, pause, stop,
    output out, busy, done
  );
endinterface

// File: rtl/mydowncounter.sv
// Loadable down-counting timer: pulses done for one cycle when the count reaches zero.
// Build option MYDOWNCOUNTER_AUTO_RELOAD_EN reloads the count and keeps running instead.
module mydowncounter #(
  parameter int unsigned WIDTH = 4
) (
  input logic           CLK,
  input logic           RSTN,
  mydowncounter_if.slave bus
);

  localparam int unsigned CW = WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] reload_q, reload_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; priority load > stop > start > pause
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (bus.load) begin
      out_d    = bus.din;
      reload_d = bus.din;
      state_d  = IDLE;
    end else if (bus.stop) begin
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && (out_q != '0)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSED;
          end else if (out_q == '0) begin
            // Unreachable in normal use; fall back to idle rather than wrap
            state_d = IDLE;
          end else if (out_q == CW'(1)) begin
            done_d = 1'b1;
`ifdef MYDOWNCOUNTER_AUTO_RELOAD_EN
            out_d   = reload_q;
`else
            out_d   = '0;
            state_d = IDLE;
`endif
          end else begin
            out_d = out_q - CW'(1);
          end
        end
        PAUSED: begin
          // Resuming edge does not decrement
          if (!bus.pause) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mydowncounter.sv
// Directed self-checking bench for mydowncounter (WIDTH=4).
// Terminal-count expectations follow the MYDOWNCOUNTER_AUTO_RELOAD_EN build setting.
module tb_mydowncounter;

  logic CLK;
  logic RSTN;
  int   n_assert;
  int   n_fail;

  mydowncounter_if #(.WIDTH(4)) bus ();

  mydowncounter #(.WIDTH(4)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int o, input int b, input int d);
    check({tag, ".out"},  32'(bus.out),  32'(o));
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".done"}, 32'(bus.done), 32'(d));
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    RSTN      = 1'b0;
    bus.load  = 1'b1;
    bus.din   = 4'd9;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;

    // Reset beats a simultaneous load
    step();
    check_all("reset", 0, 0, 0);
    RSTN     = 1'b1;
    bus.load = 1'b0;

    // Start with a zero count is ignored
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("start_zero", 0, 0, 0);
    step();
    check_all("start_zero2", 0, 0, 0);

    // Load mid-run aborts without done
    bus.load = 1'b1; bus.din = 4'd7;
    step();
    bus.load = 1'b0;
    check_all("ld7", 7, 0, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("ld7_start", 7, 1, 0);
    step();
    check_all("ld7_dec", 6, 1, 0);
    bus.load = 1'b1; bus.din = 4'd2;
    step();
    bus.load = 1'b0;
    check_all("midload", 2, 0, 0);
    step();
    check_all("midload_idle", 2, 0, 0);

    // Simultaneous load and start: load wins and stays idle
    bus.load = 1'b1; bus.din = 4'd6; bus.start = 1'b1;
    step();
    bus.load = 1'b0; bus.start = 1'b0;
    check_all("load_start", 6, 0, 0);
    step();
    check_all("load_start2", 6, 0, 0);

`ifdef MYDOWNCOUNTER_AUTO_RELOAD_EN
    // Auto-reload: period equals the reload value
    bus.load = 1'b1; bus.din = 4'd3;
    step();
    bus.load = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("ar_start", 3, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      int exp_o;
      exp_o = (i % 3 == 0) ? 3 : 3 - (i % 3);
      step();
      check_all($sformatf("ar_%0d", i), exp_o, 1, (i % 3 == 0) ? 1 : 0);
    end
    step();
    check_all("ar_10", 2, 1, 0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check_all("ar_stop", 2, 0, 0);
    step();
    check_all("ar_idle", 2, 0, 0);

    // Reset from a running state
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("ar_rerun", 2, 1, 0);
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    check_all("ar_reset", 0, 0, 0);
`else
    // Basic count from 5
    bus.load = 1'b1; bus.din = 4'd5;
    step();
    bus.load = 1'b0;
    check_all("ld5", 5, 0, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("cnt_start", 5, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_all($sformatf("cnt_%0d", i), 5 - i, (i < 5) ? 1 : 0, (i == 5) ? 1 : 0);
    end
    step();
    check_all("cnt_after", 0, 0, 0);

    // Pause for two cycles after the first decrement
    bus.load = 1'b1; bus.din = 4'd3;
    step();
    bus.load = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("p_start", 3, 1, 0);
    step();
    check_all("p_dec1", 2, 1, 0);
    bus.pause = 1'b1;
    step();
    check_all("p_hold1", 2, 1, 0);
    step();
    check_all("p_hold2", 2, 1, 0);
    bus.pause = 1'b0;
    step();
    check_all("p_resume", 2, 1, 0);
    step();
    check_all("p_dec2", 1, 1, 0);
    step();
    check_all("p_done", 0, 0, 1);
    step();
    check_all("p_after", 0, 0, 0);

    // Stop keeps the count, restart finishes it
    bus.load = 1'b1; bus.din = 4'd7;
    step();
    bus.load = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    check_all("ab_run", 4, 1, 0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check_all("ab_stop", 4, 0, 0);
    step();
    check_all("ab_idle", 4, 0, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("ab_restart", 4, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_all($sformatf("ab_%0d", i), 4 - i, (i < 4) ? 1 : 0, (i == 4) ? 1 : 0);
    end
    step();
    check_all("ab_after", 0, 0, 0);

    // Full-scale count with no wrap
    bus.load = 1'b1; bus.din = 4'd15;
    step();
    bus.load = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      check_all($sformatf("w_%0d", i), 15 - i, (i < 15) ? 1 : 0, (i == 15) ? 1 : 0);
    end
    step();
    check_all("w_nowrap", 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mydowncounter.md
# mydowncounter

Loadable down-counting timer: the count-down counterpart of the 4-bit up counter. A value is loaded, counted down by one per enabled clock, and signalled with a one-cycle `done` pulse on reaching zero. It is the timeout/delay element for handshake and pacing logic that needs "wait N cycles" behaviour.

## Interface
- `WIDTH`, 4: counter width in bits; legal range 2..16.
- `CLK`  in  1  counter clock; all state updates on its rising edge.
- `RSTN`  in  1  synchronous active-low reset, sampled on the rising edge of `CLK`.
- `load`  in  1  capture `din` into both `out` and the reload register.
- `din`  in  WIDTH  load value, unsigned.
- `start`  in  1  begin counting from the current `out`.
- `pause`  in  1  level; freezes counting while high.
- `stop`  in  1  abort counting, keep current `out`.
- `out`  out  WIDTH  current count, unsigned, registered.
- `busy`  out  1  high in RUN or PAUSED.
- `done`  out  1  one-cycle pulse when count reaches terminal.

## Operation
- Reset (`RSTN`=0 at an edge): state IDLE, `out`=0, reload=0, `busy`=0, `done`=0. Reset overrides all other inputs.
- Input priority per edge: `RSTN` > `load` > `stop` > `start` > `pause`.
- `done` defaults to 0 every cycle; it is set only by the terminal transition below.
- States:
  - IDLE: `out` holds. `load` → `out`=reload=`din`, stay IDLE. `start` with `out`≠0 → RUN. `start` with `out`=0 → ignored, no `done`.
  - RUN: `pause`=0 → `out`=`out`−1. `pause`=1 → PAUSED, `out` holds.
  - PAUSED: `out` holds; `pause`=0 → RUN (no decrement on the resuming edge).
- Terminal transition (in RUN, `pause`=0, `out`=1): `done`=1 for exactly the next cycle; see Configuration for `out`/state.
- `load` in RUN/PAUSED: abort, `out`=reload=`din`, → IDLE, no `done`.
- `stop` in RUN/PAUSED: → IDLE, `out` holds, no `done`. `stop` in IDLE: no effect.
- `start` in RUN/PAUSED: ignored.
- `out` never wraps below 0; decrement only from `out`≥1, no underflow possible.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `start` at edge k with `out`=N: `busy`=1 from edge k; `out`=N−1 after edge k+1; `out`=0, `done`=1, after edge k+N (no pauses). Start-to-`done` latency = N edges.
- Each cycle in PAUSED, plus the resuming edge, adds one cycle to latency.
- `busy` falls on the same edge that `done` rises (non-reload build).
- `load` takes effect on the sampling edge; `out` shows `din` in the following cycle.

## Configuration
- Macro `MYDOWNCOUNTER_AUTO_RELOAD_EN`.
- Undefined: terminal transition sets `out`=0, state → IDLE, `busy`=0.
- Defined: terminal transition sets `out`=reload, state stays RUN, `busy` stays 1; `done` pulses every reload cycles (period = reload value; reload=1 gives `done` every cycle). Only `stop`, `load` or reset leave RUN. `start` with `out`=0 still ignored.

## Test plan
- Reset: drive `RSTN`=0 one edge with `load`=1,`din`=9 → `out`=0, `busy`=0, `done`=0; no load taken.
- Basic count: `load` `din`=5, then `start` at edge k → `out` 4,3,2,1,0 after edges k+1..k+5; `done`=1 only in cycle after k+5; `busy` 0 from then on.
- Pause: WIDTH=4, load 3, start, `pause`=1 for 2 cycles after first decrement → `out` holds 2 for 3 cycles; `done` delayed 3 cycles vs. no pause.
- Abort: load 7, start, after `out`=4 assert `stop` → IDLE, `out`=4, no `done`; re-`start` → counts 3..0, `done` once. Repeat with `load` `din`=2 mid-run → `out`=2, IDLE, no `done`.
- Edges: `start` with `out`=0 → no `busy`, no `done`; WIDTH=4 load 15 → 15 decrements to 0, no wrap; simultaneous `load`+`start` → load wins, stays IDLE.
- Auto-reload build: load 3, start → `done` pulses at edges k+3, k+6, k+9, `out` sequence 2,1,3,2,1,3…; `stop` → IDLE holding current `out`.
